pipelined_decode_stage: RTL and testbench

- Next-generation RV32I/RV64I decode stage.
- Decodes the fetched instruction, reads the integrated register file with write-back bypass, and registers all operands and control into an ID/EX pipeline register.
- Detects load-use hazards (stall plus bubble) and honours flush from EX and back-pressure from EX.
- Sits between fetch and the execute stage of the pipelined core.

---
 rtl/pipelined_decode_stage.sv | 234 +++++++++++++++++++++++
 tb/tb_pipelined_decode_stage.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_decode_stage.sv
// RV32I/RV64I decode stage: decodes the instruction, reads the register file with
// write-back bypass, and registers operands and control into the ID/EX register.
module pipelined_decode_stage #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    input  logic            ex_stall,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            id_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [XLEN-1:0] ex_imm,
    output logic [2:0]      ex_alu_op,
    output logic [6:0]      ex_alu_ext,
    output logic            ex_alu_src,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_is_branch,
    output logic            ex_is_jump,
    output logic            ex_illegal
);

    localparam int unsigned REG_W = 5;
    localparam bit          IS64  = (XLEN == 64);

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    logic [6:0]       opcode;
    logic [6:0]       funct7;
    logic [2:0]       funct3;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             is_shift;

    assign opcode   = if_instr[6:0];
    assign rd       = if_instr[11:7];
    assign funct3   = if_instr[14:12];
    assign rs1      = if_instr[19:15];
    assign rs2      = if_instr[24:20];
    assign funct7   = if_instr[31:25];
    assign is_shift = (funct3 == 3'd1) || (funct3 == 3'd5);

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt5, shamt6;

    assign imm_i  = XLEN'($signed(if_instr[31:20]));
    assign imm_s  = XLEN'($signed({if_instr[31:25], if_instr[11:7]}));
    assign imm_b  = XLEN'($signed({if_instr[31], if_instr[7], if_instr[30:25],
                                   if_instr[11:8], 1'b0}));
    assign imm_u  = XLEN'($signed({if_instr[31:12], 12'h000}));
    assign imm_j  = XLEN'($signed({if_instr[31], if_instr[19:12], if_instr[20],
                                   if_instr[30:21], 1'b0}));
    assign shamt5 = XLEN'(if_instr[24:20]);
    assign shamt6 = XLEN'(if_instr[25:20]);

    // Register file; x0 is never written so it always reads zero
    logic [XLEN-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
        end else if (wb_we && (wb_rd != '0) && (32'(wb_rd) < NUM_REGS)) begin
            regs[wb_rd] <= wb_data;
        end
    end

    logic [XLEN-1:0] rs1_val, rs2_val;

    assign rs1_val = (rs1 == '0)                 ? '0      :
                     (wb_we && (wb_rd == rs1))   ? wb_data :
                     (32'(rs1) < NUM_REGS)       ? regs[rs1] : '0;
    assign rs2_val = (rs2 == '0)                 ? '0      :
                     (wb_we && (wb_rd == rs2))   ? wb_data :
                     (32'(rs2) < NUM_REGS)       ? regs[rs2] : '0;

    logic [XLEN-1:0] d_imm;
    logic [2:0]      d_alu_op;
    logic [6:0]      d_alu_ext;
    logic            d_alu_src, d_writes_rd, d_reg_write, d_mem_read, d_mem_write;
    logic            d_is_branch, d_is_jump, d_illegal, uses_rs1, uses_rs2;

    // Instruction decode
    always_comb begin
        d_imm       = '0;
        d_alu_op    = '0;
        d_alu_ext   = '0;
        d_alu_src   = 1'b0;
        d_writes_rd = 1'b0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
        d_is_branch = 1'b0;
        d_is_jump   = 1'b0;
        d_illegal   = 1'b0;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                d_imm = imm_u; d_alu_src = 1'b1; d_writes_rd = 1'b1; uses_rs1 = 1'b0;
            end
            OPC_JAL: begin
                d_imm = imm_j; d_writes_rd = 1'b1; d_is_jump = 1'b1; uses_rs1 = 1'b0;
            end
            OPC_JALR: begin
                d_imm = imm_i; d_alu_src = 1'b1; d_writes_rd = 1'b1; d_is_jump = 1'b1;
            end
            OPC_BRANCH: begin
                d_imm = imm_b; d_alu_op = funct3; d_is_branch = 1'b1; uses_rs2 = 1'b1;
            end
            OPC_LOAD: begin
                d_imm = imm_i; d_alu_src = 1'b1; d_writes_rd = 1'b1; d_mem_read = 1'b1;
            end
            OPC_STORE: begin
                d_imm = imm_s; d_alu_src = 1'b1; d_mem_write = 1'b1; uses_rs2 = 1'b1;
            end
            OPC_OP_IMM: begin
                d_alu_src = 1'b1; d_writes_rd = 1'b1; d_alu_op = funct3;
                if (is_shift) begin
                    d_imm     = IS64 ? shamt6 : shamt5;
                    d_alu_ext = IS64 ? {funct7[6:1], 1'b0} : funct7;
                end else begin
                    d_imm = imm_i;
                end
            end
            OPC_OP_IMM_32: begin
                if (IS64) begin
                    d_alu_src = 1'b1; d_writes_rd = 1'b1; d_alu_op = funct3;
                    if (is_shift) begin
                        d_imm     = shamt5;
                        d_alu_ext = {funct7[6:1], 1'b0};
                    end else begin
                        d_imm = imm_i;
                    end
                end else begin
                    d_illegal = 1'b1;
                end
            end
            OPC_OP: begin
                d_alu_op = funct3; d_alu_ext = funct7; d_writes_rd = 1'b1; uses_rs2 = 1'b1;
            end
            OPC_OP_32: begin
                if (IS64) begin
                    d_alu_op = funct3; d_alu_ext = funct7; d_writes_rd = 1'b1; uses_rs2 = 1'b1;
                end else begin
                    d_illegal = 1'b1;
                end
            end
            OPC_SYSTEM: d_imm = imm_i;
            default:    d_illegal = 1'b1;
        endcase
        d_reg_write = d_writes_rd && (rd != '0);
    end

    // Load-use hazard against the load currently sitting in ID/EX
    logic hazard;

    assign hazard = if_valid && ex_valid && ex_mem_read && (ex_rd != '0) &&
                    ((uses_rs1 && (ex_rd == rs1)) || (uses_rs2 && (ex_rd == rs2)));
    assign id_stall = hazard || ex_stall;

    // ID/EX register; control bits are cleared whenever the entry goes invalid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_rs1_val   <= '0;
            ex_rs2_val   <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_imm       <= '0;
            ex_alu_op    <= '0;
            ex_alu_ext   <= '0;
            ex_alu_src   <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_is_branch <= 1'b0;
            ex_is_jump   <= 1'b0;
            ex_illegal   <= 1'b0;
        end else if (flush || (!ex_stall && hazard)) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_is_branch <= 1'b0;
            ex_is_jump   <= 1'b0;
            ex_illegal   <= 1'b0;
        end else if (!ex_stall) begin
            ex_valid     <= if_valid;
            ex_pc        <= if_pc;
            ex_rs1_val   <= rs1_val;
            ex_rs2_val   <= rs2_val;
            ex_rs1       <= rs1;
            ex_rs2       <= rs2;
            ex_rd        <= rd;
            ex_imm       <= d_imm;
            ex_alu_op    <= d_alu_op;
            ex_alu_ext   <= d_alu_ext;
            ex_alu_src   <= d_alu_src;
            ex_reg_write <= if_valid && d_reg_write;
            ex_mem_read  <= if_valid && d_mem_read;
            ex_mem_write <= if_valid && d_mem_write;
            ex_is_branch <= if_valid && d_is_branch;
            ex_is_jump   <= if_valid && d_is_jump;
            ex_illegal   <= if_valid && d_illegal;
        end
    end

endmodule

// File: tb/tb_pipelined_decode_stage.sv
// Bench for pipelined_decode_stage: directed scenarios on XLEN=32 and XLEN=64
// instances, then randomized traffic against a behavioural decode/pipeline model.
module tb_pipelined_decode_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // XLEN=32 instance
    logic        if_valid, flush, ex_stall, wb_we;
    logic [31:0] if_instr, if_pc, wb_data;
    logic [4:0]  wb_rd;
    logic        id_stall, ex_valid, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write;
    logic        ex_is_branch, ex_is_jump, ex_illegal;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_alu_op;
    logic [6:0]  ex_alu_ext;

    pipelined_decode_stage #(.XLEN(32), .NUM_REGS(32)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .flush(flush), .ex_stall(ex_stall), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val),
        .ex_rs2_val(ex_rs2_val), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_imm(ex_imm), .ex_alu_op(ex_alu_op), .ex_alu_ext(ex_alu_ext),
        .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
        .ex_illegal(ex_illegal)
    );

    // XLEN=64 instance
    logic        if_valid_w, flush_w, ex_stall_w, wb_we_w;
    logic [31:0] if_instr_w;
    logic [63:0] if_pc_w, wb_data_w;
    logic [4:0]  wb_rd_w;
    logic        id_stall_w, ex_valid_w, ex_alu_src_w, ex_reg_write_w, ex_mem_read_w;
    logic        ex_mem_write_w, ex_is_branch_w, ex_is_jump_w, ex_illegal_w;
    logic [63:0] ex_pc_w, ex_rs1_val_w, ex_rs2_val_w, ex_imm_w;
    logic [4:0]  ex_rs1_w, ex_rs2_w, ex_rd_w;
    logic [2:0]  ex_alu_op_w;
    logic [6:0]  ex_alu_ext_w;

    pipelined_decode_stage #(.XLEN(64), .NUM_REGS(32)) dut64 (
        .clk(clk), .rst(rst), .if_valid(if_valid_w), .if_instr(if_instr_w), .if_pc(if_pc_w),
        .flush(flush_w), .ex_stall(ex_stall_w), .wb_we(wb_we_w), .wb_rd(wb_rd_w),
        .wb_data(wb_data_w), .id_stall(id_stall_w), .ex_valid(ex_valid_w), .ex_pc(ex_pc_w),
        .ex_rs1_val(ex_rs1_val_w), .ex_rs2_val(ex_rs2_val_w), .ex_rs1(ex_rs1_w),
        .ex_rs2(ex_rs2_w), .ex_rd(ex_rd_w), .ex_imm(ex_imm_w), .ex_alu_op(ex_alu_op_w),
        .ex_alu_ext(ex_alu_ext_w), .ex_alu_src(ex_alu_src_w), .ex_reg_write(ex_reg_write_w),
        .ex_mem_read(ex_mem_read_w), .ex_mem_write(ex_mem_write_w),
        .ex_is_branch(ex_is_branch_w), .ex_is_jump(ex_is_jump_w), .ex_illegal(ex_illegal_w)
    );

    // Expected decode of one instruction, derived from the ISA field rules
    typedef struct {
        logic [63:0] imm;
        logic [2:0]  op;
        logic [6:0]  ext;
        logic        src, rw, mr, mw, br, jp, ill, u1, u2;
    } exp_t;

    function automatic logic [63:0] sx(input logic [31:0] v, input int n);
        logic signed [31:0] t;
        t = v << (32 - n);
        t = t >>> (32 - n);
        return 64'(t);
    endfunction

    function automatic exp_t ref_dec(input logic [31:0] ins, input bit w);
        exp_t e;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        bit         shift, writes;
        opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        shift = (f3 == 3'd1) || (f3 == 3'd5);
        e.imm = 64'd0; e.op = 3'd0; e.ext = 7'd0;
        e.src = 0; e.mr = 0; e.mw = 0; e.br = 0; e.jp = 0; e.ill = 0; e.u1 = 1; e.u2 = 0;
        writes = 0;
        if (opc == 7'h37 || opc == 7'h17) begin
            e.imm = sx({ins[31:12], 12'h000}, 32); e.src = 1; writes = 1; e.u1 = 0;
        end else if (opc == 7'h6F) begin
            e.imm = sx({11'd0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
            e.jp = 1; writes = 1; e.u1 = 0;
        end else if (opc == 7'h67) begin
            e.imm = sx({20'd0, ins[31:20]}, 12); e.src = 1; e.jp = 1; writes = 1;
        end else if (opc == 7'h63) begin
            e.imm = sx({19'd0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
            e.op = f3; e.br = 1; e.u2 = 1;
        end else if (opc == 7'h03) begin
            e.imm = sx({20'd0, ins[31:20]}, 12); e.src = 1; e.mr = 1; writes = 1;
        end else if (opc == 7'h23) begin
            e.imm = sx({20'd0, ins[31:25], ins[11:7]}, 12); e.src = 1; e.mw = 1; e.u2 = 1;
        end else if (opc == 7'h13 || (w && opc == 7'h1B)) begin
            e.src = 1; writes = 1; e.op = f3;
            if (shift) begin
                e.imm = (w && opc == 7'h13) ? {58'd0, ins[25:20]} : {59'd0, ins[24:20]};
                e.ext = w ? (f7 & 7'h7E) : f7;
            end else begin
                e.imm = sx({20'd0, ins[31:20]}, 12);
            end
        end else if (opc == 7'h33 || (w && opc == 7'h3B)) begin
            e.op = f3; e.ext = f7; writes = 1; e.u2 = 1;
        end else if (opc == 7'h73) begin
            e.imm = sx({20'd0, ins[31:20]}, 12);
        end else begin
            e.ill = 1;
        end
        e.rw = writes && (ins[11:7] != 5'd0);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic fl, input logic st, input logic we,
                         input logic [4:0] rd, input logic [31:0] d);
        if_valid = v; if_instr = ins; if_pc = pc; flush = fl; ex_stall = st;
        wb_we = we; wb_rd = rd; wb_data = d;
    endtask

    task automatic drive_w(input logic [31:0] ins, input logic we, input logic [4:0] rd,
                           input logic [63:0] d);
        if_valid_w = 1'b1; if_instr_w = ins; if_pc_w = 64'h1000; flush_w = 1'b0;
        ex_stall_w = 1'b0; wb_we_w = we; wb_rd_w = rd; wb_data_w = d;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        drive_w(32'h0, 1'b0, 5'd0, 64'h0);
        if_valid_w = 1'b0;
        repeat (2) tick();
        checks++; if ({ex_valid, id_stall} !== 2'b00) begin errors++;
            $display("FAIL reset_valid_stall: got %b expected 00", {ex_valid, id_stall}); end
        checks++; if ({ex_pc, ex_imm, ex_rs1_val, ex_reg_write, ex_illegal} !== '0) begin errors++;
            $display("FAIL reset_fields: got %h expected 0", {ex_pc, ex_imm, ex_rs1_val}); end
        checks++; if (ex_valid_w !== 1'b0) begin errors++;
            $display("FAIL reset_valid64: got %b expected 0", ex_valid_w); end
        rst = 1'b1;
        drive(1'b1, 32'h00028313, 32'h80, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);  // addi x6,x5,0
        tick();
        checks++; if ({ex_valid, ex_rs1_val} !== {1'b1, 32'h0}) begin errors++;
            $display("FAIL reset_x5_read: got %b/%h expected 1/0", ex_valid, ex_rs1_val); end
    endtask

    task automatic test_bypass();
        drive(1'b1, 32'h00328313, 32'h100, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234);  // addi x6,x5,3
        tick();
        checks++; if (ex_rs1_val !== 32'h1234) begin errors++;
            $display("FAIL bypass_rs1: got %h expected 00001234", ex_rs1_val); end
        checks++; if ({ex_imm, ex_alu_src, ex_rd, ex_reg_write, ex_pc} !== {32'd3, 1'b1, 5'd6, 1'b1, 32'h100}) begin errors++;
            $display("FAIL bypass_ctrl: imm %h src %b rd %0d rw %b pc %h", ex_imm, ex_alu_src, ex_rd, ex_reg_write, ex_pc); end
        drive(1'b1, 32'h000284B3, 32'h104, 1'b0, 1'b0, 1'b1, 5'd0, 32'hDEAD);  // add x9,x5,x0
        tick();
        checks++; if ({ex_rs1_val, ex_rs2_val} !== {32'h1234, 32'h0}) begin errors++;
            $display("FAIL regfile_write_x0: got %h/%h expected 00001234/00000000", ex_rs1_val, ex_rs2_val); end
    endtask

    task automatic test_load_use();
        drive(1'b1, 32'h0000A383, 32'h120, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);  // lw x7,0(x1)
        tick();
        checks++; if ({ex_valid, ex_mem_read, ex_rd} !== {1'b1, 1'b1, 5'd7}) begin errors++;
            $display("FAIL load_issue: got %b%b rd %0d expected 11 rd 7", ex_valid, ex_mem_read, ex_rd); end
        drive(1'b1, 32'h00238433, 32'h124, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);  // add x8,x7,x2
        #1;
        checks++; if (id_stall !== 1'b1) begin errors++;
            $display("FAIL load_use_stall: got %b expected 1", id_stall); end
        tick();
        checks++; if ({ex_valid, id_stall, ex_mem_read} !== 3'b000) begin errors++;
            $display("FAIL load_use_bubble: got %b expected 000", {ex_valid, id_stall, ex_mem_read}); end
        tick();
        checks++; if ({ex_valid, ex_rs1, ex_rs2, ex_rd, ex_pc} !== {1'b1, 5'd7, 5'd2, 5'd8, 32'h124}) begin errors++;
            $display("FAIL load_use_add: valid %b rs1 %0d rs2 %0d rd %0d pc %h", ex_valid, ex_rs1, ex_rs2, ex_rd, ex_pc); end
    endtask

    task automatic test_stall_flush();
        drive(1'b1, 32'h00208463, 32'h200, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);  // beq x1,x2,+8
        tick();
        checks++; if ({ex_is_branch, ex_imm, ex_alu_op} !== {1'b1, 32'd8, 3'd0}) begin errors++;
            $display("FAIL beq_decode: br %b imm %h op %0d", ex_is_branch, ex_imm, ex_alu_op); end
        drive(1'b1, 32'h00328313, 32'h204, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        #1;
        checks++; if (id_stall !== 1'b1) begin errors++;
            $display("FAIL ex_stall_id_stall: got %b expected 1", id_stall); end
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if ({ex_valid, ex_is_branch, ex_pc, ex_imm, ex_rd} !== {1'b1, 1'b1, 32'h200, 32'd8, 5'd8}) begin errors++;
                $display("FAIL stall_hold%0d: valid %b br %b pc %h imm %h", c, ex_valid, ex_is_branch, ex_pc, ex_imm); end
        end
        drive(1'b1, 32'h00328313, 32'h204, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
        tick();
        checks++; if ({ex_valid, ex_is_branch, ex_reg_write} !== 3'b000) begin errors++;
            $display("FAIL flush_over_stall: got %b expected 000", {ex_valid, ex_is_branch, ex_reg_write}); end
    endtask

    task automatic test_imm();
        drive(1'b1, 32'hFFDFF0EF, 32'h300, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);  // jal x1,-4
        tick();
        checks++; if ({ex_imm, ex_is_jump, ex_reg_write} !== {32'hFFFFFFFC, 1'b1, 1'b1}) begin errors++;
            $display("FAIL jal_imm: imm %h jump %b rw %b", ex_imm, ex_is_jump, ex_reg_write); end
        drive(1'b1, 32'hFE512C23, 32'h304, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);  // sw x5,-8(x2)
        tick();
        checks++; if ({ex_imm, ex_mem_write, ex_reg_write, ex_rs2} !== {32'hFFFFFFF8, 1'b1, 1'b0, 5'd5}) begin errors++;
            $display("FAIL sw_imm: imm %h mw %b rw %b rs2 %0d", ex_imm, ex_mem_write, ex_reg_write, ex_rs2); end
        drive(1'b1, 32'hFFF1819B, 32'h308, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);  // addiw on RV32
        tick();
        checks++; if ({ex_illegal, ex_reg_write} !== 2'b10) begin errors++;
            $display("FAIL rv32_addiw_illegal: got %b expected 10", {ex_illegal, ex_reg_write}); end
    endtask

    task automatic test_xlen64();
        drive_w(32'h02819193, 1'b0, 5'd0, 64'h0);  // slli x3,x3,40
        tick();
        checks++; if ({ex_imm_w, ex_alu_ext_w, ex_alu_op_w} !== {64'd40, 7'h00, 3'd1}) begin errors++;
            $display("FAIL rv64_slli: imm %h ext %h op %0d", ex_imm_w, ex_alu_ext_w, ex_alu_op_w); end
        drive_w(32'h4211D193, 1'b0, 5'd0, 64'h0);  // srai x3,x3,33
        tick();
        checks++; if ({ex_imm_w, ex_alu_ext_w, ex_alu_op_w} !== {64'd33, 7'h20, 3'd5}) begin errors++;
            $display("FAIL rv64_srai: imm %h ext %h op %0d", ex_imm_w, ex_alu_ext_w, ex_alu_op_w); end
        drive_w(32'hFFF1819B, 1'b1, 5'd3, 64'h0123_4567_89AB_CDEF);  // addiw x3,x3,-1
        tick();
        checks++; if ({ex_illegal_w, ex_reg_write_w, ex_imm_w, ex_rs1_val_w} !== {1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF}) begin errors++;
            $display("FAIL rv64_addiw: ill %b rw %b imm %h rs1 %h", ex_illegal_w, ex_reg_write_w, ex_imm_w, ex_rs1_val_w); end
        drive_w(32'h000001FF, 1'b0, 5'd0, 64'h0);  // opcode 0x7F
        tick();
        checks++; if ({ex_valid_w, ex_illegal_w, ex_reg_write_w, ex_mem_read_w, ex_is_jump_w} !== 5'b11000) begin errors++;
            $display("FAIL rv64_illegal: got %b expected 11000", {ex_valid_w, ex_illegal_w, ex_reg_write_w, ex_mem_read_w, ex_is_jump_w}); end
        if_valid_w = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] mrf [32];
        logic [6:0]  opcs [12];
        exp_t        e, m_e;
        logic        m_valid, hz;
        logic [31:0] m_pc, m_r1v, m_r2v, x1v, x2v, ins;
        logic [4:0]  m_rs1, m_rs2, m_rd, r1, r2;
        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h1B, 7'h3B};
        for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
        m_e = ref_dec(32'h0, 1'b0);
        m_valid = 0; m_pc = 0; m_r1v = 0; m_r2v = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        rst = 1'b1;
        for (int n = 0; n < 800; n++) begin
            ins = $urandom;
            if ($urandom_range(0, 12) == 0) ins[6:0] = 7'($urandom);
            else ins[6:0] = opcs[$urandom_range(0, 11)];
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            drive($urandom_range(0, 4) != 0, ins, $urandom, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 6) == 0, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 7)), $urandom);
            #1;
            e  = ref_dec(ins, 1'b0);
            r1 = ins[19:15];
            r2 = ins[24:20];
            x1v = (r1 == 0) ? 32'h0 : (wb_we && wb_rd == r1) ? wb_data : mrf[r1];
            x2v = (r2 == 0) ? 32'h0 : (wb_we && wb_rd == r2) ? wb_data : mrf[r2];
            hz = if_valid && m_valid && m_e.mr && (m_rd != 0) &&
                 ((e.u1 && m_rd == r1) || (e.u2 && m_rd == r2));
            checks++; if (id_stall !== (hz || ex_stall)) begin errors++;
                $display("FAIL rand_id_stall cycle %0d: got %b expected %b", n, id_stall, hz || ex_stall); end
            if (flush || (!ex_stall && hz)) begin
                m_valid = 0;
            end else if (!ex_stall) begin
                m_valid = if_valid; m_e = e; m_pc = if_pc; m_r1v = x1v; m_r2v = x2v;
                m_rs1 = r1; m_rs2 = r2; m_rd = ins[11:7];
            end
            if (wb_we && wb_rd != 0) mrf[wb_rd] = wb_data;
            tick();
            checks++;
            if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch, ex_is_jump, ex_illegal} !==
                {m_valid, m_valid && m_e.rw, m_valid && m_e.mr, m_valid && m_e.mw,
                 m_valid && m_e.br, m_valid && m_e.jp, m_valid && m_e.ill}) begin errors++;
                $display("FAIL rand_ctrl cycle %0d: got %b expected %b", n,
                    {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch, ex_is_jump, ex_illegal},
                    {m_valid, m_valid && m_e.rw, m_valid && m_e.mr, m_valid && m_e.mw,
                     m_valid && m_e.br, m_valid && m_e.jp, m_valid && m_e.ill}); end
            if (m_valid) begin
                checks++;
                if ({ex_pc, ex_rs1_val, ex_rs2_val, ex_rs1, ex_rs2, ex_rd, ex_imm, ex_alu_op, ex_alu_ext, ex_alu_src} !==
                    {m_pc, m_r1v, m_r2v, m_rs1, m_rs2, m_rd, m_e.imm[31:0], m_e.op, m_e.ext, m_e.src}) begin errors++;
                    $display("FAIL rand_data cycle %0d: got %h expected %h", n,
                        {ex_pc, ex_rs1_val, ex_rs2_val, ex_rs1, ex_rs2, ex_rd, ex_imm, ex_alu_op, ex_alu_ext, ex_alu_src},
                        {m_pc, m_r1v, m_r2v, m_rs1, m_rs2, m_rd, m_e.imm[31:0], m_e.op, m_e.ext, m_e.src}); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_load_use();
        test_stall_flush();
        test_imm();
        test_xlen64();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
